pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the load and bubble/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, and arbitrates between cache-miss freezes, branch-mispredict redirects, multi-cycle mul/div occupancy and load-use interlocks. A small FSM holds a redirect that arrives during a memory freeze, so no mispredict is ever lost.

---
 rtl/rv32i_types.sv | 35 +++
 rtl/hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: controller state encoding and per-register
// load/flush/bubble control bundle with its canonical patterns.
package rv32i_types;

    localparam int unsigned PIPE_STATE_W = 2;

    typedef enum logic [PIPE_STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2,
        REDIRECT = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic bubble_id_ex;
    } pipe_ctrl_t;

    // Whole pipeline frozen (memory miss, reset, waiting to redirect)
    localparam pipe_ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Every stage advances
    localparam pipe_ctrl_t CTRL_ADVANCE  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Squash both younger stages while loading the branch target
    localparam pipe_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Mul/div occupies EX; only MEM/WB keeps draining
    localparam pipe_ctrl_t CTRL_MULDIV   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // Hold IF/ID, insert one bubble into EX
    localparam pipe_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an
// in-flight load in EX has not yet produced. x0 never creates a hazard.
module hazard_detect
    import rv32i_types::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use_c = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline.
// Optional build macro PIPELINE_CTRL_PERF_EN adds saturating counters for
// memory-freeze cycles, redirect flushes and load-use bubbles.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned REG_ADDR_W = 5
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_stall,
    input  logic                  dmem_stall,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mispredict,
    input  logic                  ex_muldiv_start,
    input  logic                  muldiv_done,
    output logic                  load_pc,
    output logic                  load_if_id,
    output logic                  load_id_ex,
    output logic                  load_ex_mem,
    output logic                  load_mem_wb,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic                  pc_redirect,
    output logic [1:0]            stall_state
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_mem_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt,
    output logic [CNT_W-1:0]      perf_loaduse_cnt
`endif
);

    pipe_state_t state;
    pipe_state_t state_next;
    logic        redirect_pending;
    logic        pending_next;
    pipe_ctrl_t  ctrl;
    logic        load_use_c;
    logic        run_cycle;
    logic        freeze_applied;
    logic        redirect_applied;
    logic        loaduse_applied;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use_c (load_use_c)
    );

    // Priority arbitration: freeze > redirect > mul/div > load-use > advance
    always_comb begin
        ctrl             = CTRL_HOLD;
        pc_redirect      = 1'b0;
        state_next       = state;
        pending_next     = redirect_pending;
        run_cycle        = 1'b0;
        freeze_applied   = 1'b0;
        redirect_applied = 1'b0;
        loaduse_applied  = 1'b0;

        if (!rst) begin
            if (imem_stall || dmem_stall) begin
                // Nothing moves; a mispredict seen now is replayed after the miss
                freeze_applied = 1'b1;
                if (ex_mispredict) begin
                    pending_next = 1'b1;
                end
                state_next = (state == MULDIV) ? MULDIV : MEM_WAIT;
            end else begin
                case (state)
                    REDIRECT: redirect_applied = 1'b1;
                    MULDIV: begin
                        if (muldiv_done) begin
                            ctrl       = CTRL_ADVANCE;
                            state_next = RUN;
                        end else begin
                            ctrl = CTRL_MULDIV;
                        end
                    end
                    MEM_WAIT: begin
                        if (redirect_pending) begin
                            state_next = REDIRECT;
                        end else begin
                            run_cycle = 1'b1;
                        end
                    end
                    default: run_cycle = 1'b1;
                endcase

                if (run_cycle) begin
                    state_next = RUN;
                    if (ex_mispredict) begin
                        redirect_applied = 1'b1;
                    end else if (ex_muldiv_start) begin
                        ctrl       = CTRL_MULDIV;
                        state_next = MULDIV;
                    end else if (load_use_c) begin
                        ctrl            = CTRL_LOADUSE;
                        loaduse_applied = 1'b1;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end

                if (redirect_applied) begin
                    ctrl         = CTRL_REDIRECT;
                    pc_redirect  = 1'b1;
                    pending_next = 1'b0;
                    state_next   = RUN;
                end
            end
        end
    end

    // State and pending-redirect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_next;
            redirect_pending <= pending_next;
        end
    end

    assign load_pc      = ctrl.load_pc;
    assign load_if_id   = ctrl.load_if_id;
    assign load_id_ex   = ctrl.load_id_ex;
    assign load_ex_mem  = ctrl.load_ex_mem;
    assign load_mem_wb  = ctrl.load_mem_wb;
    assign flush_if_id  = ctrl.flush_if_id;
    assign bubble_id_ex = ctrl.bubble_id_ex;
    assign stall_state  = 2'(state);

`ifdef PIPELINE_CTRL_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall_cnt <= '0;
            perf_flush_cnt     <= '0;
            perf_loaduse_cnt   <= '0;
        end else begin
            if (freeze_applied && (perf_mem_stall_cnt != '1)) begin
                perf_mem_stall_cnt <= perf_mem_stall_cnt + CNT_W'(1);
            end
            if (redirect_applied && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
            if (loaduse_applied && (perf_loaduse_cnt != '1)) begin
                perf_loaduse_cnt <= perf_loaduse_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl. Output vector order:
// {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id,
//  bubble_id_ex, pc_redirect}.
module tb_pipeline_ctrl;

    localparam logic [7:0] E_HOLD = 8'b0000_0000;
    localparam logic [7:0] E_ADV  = 8'b1111_1000;
    localparam logic [7:0] E_RED  = 8'b1111_1111;
    localparam logic [7:0] E_MDW  = 8'b0000_1000;
    localparam logic [7:0] E_LU   = 8'b0011_1010;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_stall, dmem_stall;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load;
    logic       ex_mispredict, ex_muldiv_start, muldiv_done;
    logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic       flush_if_id, bubble_id_ex, pc_redirect;
    logic [1:0] stall_state;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_mem_stall_cnt, perf_flush_cnt, perf_loaduse_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .imem_stall      (imem_stall),
        .dmem_stall      (dmem_stall),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_mispredict   (ex_mispredict),
        .ex_muldiv_start (ex_muldiv_start),
        .muldiv_done     (muldiv_done),
        .load_pc         (load_pc),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .flush_if_id     (flush_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .pc_redirect     (pc_redirect),
        .stall_state     (stall_state)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_mem_stall_cnt (perf_mem_stall_cnt),
        .perf_flush_cnt     (perf_flush_cnt),
        .perf_loaduse_cnt   (perf_loaduse_cnt)
`endif
    );

    function automatic logic [7:0] outs();
        return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, bubble_id_ex, pc_redirect};
    endfunction

    task automatic idle_inputs();
        imem_stall = 0; dmem_stall = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_is_load = 0; ex_rd = 0;
        ex_mispredict = 0; ex_muldiv_start = 0; muldiv_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs() !== E_HOLD || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold: outs=%b state=%0d expected outs=%b state=0", outs(), stall_state, E_HOLD);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs() !== E_ADV || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_release_advance: outs=%b state=%0d expected outs=%b state=0", outs(), stall_state, E_ADV);
        end
        next_cycle();
    endtask

    // Exactly one bubble cycle on a load-use match, then normal flow
    task automatic test_load_use();
        logic [7:0] exp_o;
        for (int v = 0; v < 5; v++) begin
            idle_inputs();
            ex_is_load = 1'b1;
            case (v)
                0: begin ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; exp_o = E_LU;  end
                1: begin ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1; exp_o = E_LU; end
                2: begin ex_rd = 9; id_rs1 = 9; id_use_rs1 = 0; exp_o = E_ADV; end
                3: begin ex_is_load = 0; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1; exp_o = E_ADV; end
                default: begin ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; exp_o = E_ADV; end
            endcase
            @(negedge clk);
            vectors++;
            if (outs() !== exp_o || stall_state !== 2'd0) begin
                miscompares++;
                $display("FAIL load_use_v%0d: outs=%b state=%0d expected outs=%b state=0", v, outs(), stall_state, exp_o);
            end
            next_cycle();
            idle_inputs();
            @(negedge clk);
            vectors++;
            if (outs() !== E_ADV || stall_state !== 2'd0) begin
                miscompares++;
                $display("FAIL load_use_after_v%0d: outs=%b state=%0d expected outs=%b state=0", v, outs(), stall_state, E_ADV);
            end
            next_cycle();
        end
    endtask

    // dmem miss for 4 cycles, mispredict in cycle 2 held until after the miss
    task automatic test_freeze_redirect();
        logic [7:0] exp_o;
        logic [1:0] exp_s;
        for (int i = 1; i <= 7; i++) begin
            idle_inputs();
            dmem_stall    = (i <= 4);
            ex_mispredict = (i == 2);
            exp_o = (i <= 5) ? E_HOLD : ((i == 6) ? E_RED : E_ADV);
            exp_s = (i == 1 || i == 7) ? 2'd0 : ((i == 6) ? 2'd3 : 2'd1);
            @(negedge clk);
            vectors++;
            if (outs() !== exp_o || stall_state !== exp_s) begin
                miscompares++;
                $display("FAIL freeze_redirect_c%0d: outs=%b state=%0d expected outs=%b state=%0d", i, outs(), stall_state, exp_o, exp_s);
            end
            next_cycle();
        end
        // Plain I-cache miss: release cycle advances straight from MEM_WAIT
        for (int i = 1; i <= 4; i++) begin
            idle_inputs();
            imem_stall = (i <= 2);
            exp_o = (i <= 2) ? E_HOLD : E_ADV;
            exp_s = (i == 1 || i == 4) ? 2'd0 : 2'd1;
            @(negedge clk);
            vectors++;
            if (outs() !== exp_o || stall_state !== exp_s) begin
                miscompares++;
                $display("FAIL imem_freeze_c%0d: outs=%b state=%0d expected outs=%b state=%0d", i, outs(), stall_state, exp_o, exp_s);
            end
            next_cycle();
        end
    endtask

    // 33 held cycles from launch, release in the muldiv_done cycle
    task automatic test_muldiv();
        logic [7:0] exp_o;
        logic [1:0] exp_s;
        for (int i = 0; i <= 34; i++) begin
            idle_inputs();
            ex_muldiv_start = (i == 0);
            muldiv_done     = (i == 33);
            exp_o = (i >= 33) ? E_ADV : E_MDW;
            exp_s = (i == 0 || i == 34) ? 2'd0 : 2'd2;
            @(negedge clk);
            vectors++;
            if (outs() !== exp_o || stall_state !== exp_s) begin
                miscompares++;
                $display("FAIL muldiv_c%0d: outs=%b state=%0d expected outs=%b state=%0d", i, outs(), stall_state, exp_o, exp_s);
            end
            next_cycle();
        end
        // Freeze inside MULDIV stalls everything but keeps the state
        for (int i = 0; i <= 4; i++) begin
            idle_inputs();
            ex_muldiv_start = (i == 0);
            dmem_stall      = (i == 2);
            muldiv_done     = (i == 3);
            exp_o = (i == 2) ? E_HOLD : ((i >= 3) ? E_ADV : E_MDW);
            exp_s = (i == 0 || i == 4) ? 2'd0 : 2'd2;
            @(negedge clk);
            vectors++;
            if (outs() !== exp_o || stall_state !== exp_s) begin
                miscompares++;
                $display("FAIL muldiv_freeze_c%0d: outs=%b state=%0d expected outs=%b state=%0d", i, outs(), stall_state, exp_o, exp_s);
            end
            next_cycle();
        end
    endtask

    // Redirect squashes a same-cycle load-use or mul/div launch
    task automatic test_redirect_priority();
        for (int v = 0; v < 2; v++) begin
            idle_inputs();
            ex_mispredict = 1'b1;
            if (v == 0) begin
                ex_is_load = 1; ex_rd = 12; id_rs1 = 12; id_use_rs1 = 1;
            end else begin
                ex_muldiv_start = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (outs() !== E_RED || stall_state !== 2'd0) begin
                miscompares++;
                $display("FAIL redirect_prio_v%0d: outs=%b state=%0d expected outs=%b state=0", v, outs(), stall_state, E_RED);
            end
            next_cycle();
            idle_inputs();
            @(negedge clk);
            vectors++;
            if (outs() !== E_ADV || stall_state !== 2'd0) begin
                miscompares++;
                $display("FAIL redirect_prio_after_v%0d: outs=%b state=%0d expected outs=%b state=0", v, outs(), stall_state, E_ADV);
            end
            next_cycle();
        end
    endtask

    // Reset in the middle of a mul/div wait
    task automatic test_reset_in_muldiv();
        idle_inputs();
        ex_muldiv_start = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (stall_state !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_muldiv_entered: state=%0d expected state=2", stall_state);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        vectors++;
        if (perf_mem_stall_cnt !== 32'd7 || perf_flush_cnt !== 32'd3 || perf_loaduse_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL perf_counts: mem=%0d flush=%0d lu=%0d expected mem=7 flush=3 lu=2",
                     perf_mem_stall_cnt, perf_flush_cnt, perf_loaduse_cnt);
        end
`endif
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs() !== E_HOLD) begin
            miscompares++;
            $display("FAIL rst_muldiv_outs: outs=%b expected outs=%b", outs(), E_HOLD);
        end
        next_cycle();
        vectors++;
        if (outs() !== E_HOLD || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_muldiv_state: outs=%b state=%0d expected outs=%b state=0", outs(), stall_state, E_HOLD);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        vectors++;
        if (perf_mem_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0 || perf_loaduse_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL perf_reset: mem=%0d flush=%0d lu=%0d expected all 0",
                     perf_mem_stall_cnt, perf_flush_cnt, perf_loaduse_cnt);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs() !== E_ADV || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_muldiv_release: outs=%b state=%0d expected outs=%b state=0", outs(), stall_state, E_ADV);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_freeze_redirect();
        test_muldiv();
        test_redirect_priority();
        test_reset_in_muldiv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
